// File: rtl/debouncer_pkg.sv
// Shared types and constants for the switch debouncer: FSM state encoding,
// qualification length and tick-divider helpers.
package debouncer_pkg;

    typedef enum logic [2:0] {
        ZERO    = 3'd0,
        WAIT1_1 = 3'd1,
        WAIT1_2 = 3'd2,
        WAIT1_3 = 3'd3,
        ONE     = 3'd4,
        WAIT0_1 = 3'd5,
        WAIT0_2 = 3'd6,
        WAIT0_3 = 3'd7
    } state_t;

    localparam int WAIT_TICKS  = 3;
    localparam int SYNC_STAGES = 2;

    function automatic int calc_div(input int clk_rate, input int baud);
        return clk_rate / baud;
    endfunction

    function automatic int calc_cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/debouncer_tick_gen.sv
// Free-running sample-tick divider: one-cycle tick every DIV clocks, counter
// restarts only on reset.
module debouncer_tick_gen
    import debouncer_pkg::*;
#(
    parameter int ClkRate = 100_000_000,
    parameter int Baud    = 10_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int DIV = calc_div(ClkRate, Baud);
    localparam int CW  = calc_cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick_o = (count_reg == LAST);

endmodule

// File: rtl/debouncer.sv
// Switch debouncer: synchronizes the raw input, qualifies each new level over
// WAIT_TICKS sample ticks, and emits a registered level plus rising-edge pulse.
module debouncer
    import debouncer_pkg::*;
#(
    parameter int ClkRate = 100_000_000,
    parameter int Baud    = 10_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic db_level_o,
    output logic db_tick_o
);

    logic tick;

    debouncer_tick_gen #(
        .ClkRate(ClkRate),
        .Baud   (Baud)
    ) u_tick_gen (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick_o(tick)
    );

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sw_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sw_i};
        end
    end

    assign sw_s = sync_reg[SYNC_STAGES-1];

    state_t state_reg, state_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ZERO;
        end else begin
            state_reg <= state_next;
        end
    end

    // A revert of sw_s is checked before tick so a bounce always wins.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ZERO:    if (sw_s) state_next = WAIT1_1;
            WAIT1_1: if (!sw_s) state_next = ZERO; else if (tick) state_next = WAIT1_2;
            WAIT1_2: if (!sw_s) state_next = ZERO; else if (tick) state_next = WAIT1_3;
            WAIT1_3: if (!sw_s) state_next = ZERO; else if (tick) state_next = ONE;
            ONE:     if (!sw_s) state_next = WAIT0_1;
            WAIT0_1: if (sw_s) state_next = ONE; else if (tick) state_next = WAIT0_2;
            WAIT0_2: if (sw_s) state_next = ONE; else if (tick) state_next = WAIT0_3;
            WAIT0_3: if (sw_s) state_next = ONE; else if (tick) state_next = ZERO;
            default: state_next = ZERO;
        endcase
    end

    logic db_level_reg, db_level_next;
    logic db_tick_reg, db_tick_next;

    // The level register still holds 0 during the first cycle in ONE only
    // when ONE was reached from WAIT1_3, which isolates the rising-edge pulse.
    always_comb begin
        db_level_next = (state_reg == ONE) || (state_reg == WAIT0_1) ||
                        (state_reg == WAIT0_2) || (state_reg == WAIT0_3);
        db_tick_next  = (state_reg == ONE) && !db_level_reg;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            db_level_reg <= 1'b0;
            db_tick_reg  <= 1'b0;
        end else begin
            db_level_reg <= db_level_next;
            db_tick_reg  <= db_tick_next;
        end
    end

    assign db_level_o = db_level_reg;
    assign db_tick_o  = db_tick_reg;

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer: directed latency/glitch sequences, a
// pulse-length table, and random stimulus against a tick-counting model.
module tb_debouncer;

    localparam int CLK_RATE = 100_000_000;
    localparam int BAUD     = 10_000_000;
    localparam int DIV      = CLK_RATE / BAUD;
    localparam int MIN_LAT  = 2 * DIV + 4;
    localparam int MAX_LAT  = 3 * DIV + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw  = 1'b1;
    logic db_level;
    logic db_tick;

    always #5 clk = ~clk;

    debouncer #(
        .ClkRate(CLK_RATE),
        .Baud   (BAUD)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .sw_i      (sw),
        .db_level_o(db_level),
        .db_tick_o (db_tick)
    );

    // Reference model: the accepted level flips once the synchronized input
    // has disagreed with it across three sample ticks without reverting.
    logic m_q1, m_q2, m_acc, m_level, m_tick, m_pend;
    int   m_phase, m_ticks;
    wire  m_sample = (m_phase == DIV - 1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q1    <= 1'b0;
            m_q2    <= 1'b0;
            m_acc   <= 1'b0;
            m_level <= 1'b0;
            m_tick  <= 1'b0;
            m_pend  <= 1'b0;
            m_phase <= 0;
            m_ticks <= 0;
        end else begin
            m_q1    <= sw;
            m_q2    <= m_q1;
            m_phase <= (m_phase + 1) % DIV;
            m_level <= m_acc;
            m_tick  <= m_acc && !m_level;
            if (!m_pend) begin
                if (m_q2 != m_acc) begin
                    m_pend  <= 1'b1;
                    m_ticks <= 0;
                end
            end else if (m_q2 == m_acc) begin
                m_pend <= 1'b0;
            end else if (m_sample) begin
                if (m_ticks + 1 == 3) begin
                    m_acc  <= ~m_acc;
                    m_pend <= 1'b0;
                end else begin
                    m_ticks <= m_ticks + 1;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int model_fail_prints = 0;
    int tick_cnt = 0;
    int chg_cnt = 0;
    int n_edges = 0;
    int last_tick_edge = -1;
    logic prev_level = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Advance one clock; sample on the falling edge and compare with the model.
    task automatic step();
        @(negedge clk);
        n_edges++;
        if (!rst) begin
            checks++;
            if (db_level !== m_level || db_tick !== m_tick) begin
                errors++;
                if (model_fail_prints < 30) begin
                    model_fail_prints++;
                    $display("FAIL model t=%0t level=%b/%b tick=%b/%b (actual/expected)",
                             $time, db_level, m_level, db_tick, m_tick);
                end
            end
        end
        if (db_tick === 1'b1) begin
            tick_cnt++;
            last_tick_edge = n_edges;
        end
        if (db_level !== prev_level) chg_cnt++;
        prev_level = db_level;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Returns the edge index (0 = first posedge after the change) at which
    // db_level reaches target, or -1 after the bound expires.
    task automatic wait_level(input logic target, output int lat, output logic tick_seen);
        lat = -1;
        tick_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (db_level === target) begin
                lat = i;
                tick_seen = db_tick;
                break;
            end
        end
    endtask

    typedef struct {
        bit from_one;
        int len;
        bit accept;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int   lat;
        logic ts;
        int   s_edge;

        vecs[0] = '{1'b0, 5,  1'b0};
        vecs[1] = '{1'b0, 15, 1'b0};
        vecs[2] = '{1'b0, 20, 1'b0};
        vecs[3] = '{1'b0, 33, 1'b1};
        vecs[4] = '{1'b0, 45, 1'b1};
        vecs[5] = '{1'b1, 15, 1'b0};
        vecs[6] = '{1'b1, 20, 1'b0};
        vecs[7] = '{1'b1, 40, 1'b1};

        // Reset held with the switch pressed.
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_level", int'(db_level), 0);
            check("reset_tick", int'(db_tick), 0);
        end
        $display("reset: held 5 cycles with sw=1");
        sw  = 1'b0;
        rst = 1'b0;
        steps(45);

        // Clean press.
        tick_cnt = 0;
        sw = 1'b1;
        wait_level(1'b1, lat, ts);
        check_range("press_latency", lat, MIN_LAT, MAX_LAT);
        check("press_tick_same_cycle", int'(ts), 1);
        steps(50 - lat - 1);
        check("press_tick_count", tick_cnt, 1);
        $display("clean press: latency %0d ticks %0d", lat, tick_cnt);

        // Release.
        tick_cnt = 0;
        sw = 1'b0;
        wait_level(1'b0, lat, ts);
        check_range("release_latency", lat, MIN_LAT, MAX_LAT);
        steps(50 - lat - 1);
        check("release_tick_count", tick_cnt, 0);
        $display("release: latency %0d ticks %0d", lat, tick_cnt);

        // Bouncy press ending in a held 1.
        tick_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) sw = ~sw;
            step();
        end
        sw = 1'b1;
        s_edge = n_edges;
        steps(45);
        check("bounce_tick_count", tick_cnt, 1);
        check_range("bounce_latency", last_tick_edge - s_edge - 1, MIN_LAT, MAX_LAT);
        $display("bouncy press: ticks %0d latency %0d", tick_cnt, last_tick_edge - s_edge - 1);

        // Pulse-length table.
        foreach (vecs[v]) begin
            sw = vecs[v].from_one;
            steps(45);
            tick_cnt = 0;
            chg_cnt  = 0;
            sw = ~vecs[v].from_one;
            steps(vecs[v].len);
            sw = vecs[v].from_one;
            steps(45);
            check($sformatf("vec%0d_changes", v), chg_cnt, vecs[v].accept ? 2 : 0);
            check($sformatf("vec%0d_ticks", v), tick_cnt, vecs[v].accept ? 1 : 0);
            $display("vector %0d: from_one=%0d len=%0d changes=%0d ticks=%0d",
                     v, vecs[v].from_one, vecs[v].len, chg_cnt, tick_cnt);
        end

        // Reset in the middle of a press qualification.
        sw = 1'b0;
        steps(45);
        sw = 1'b1;
        steps(10);
        rst = 1'b1;
        #1;
        check("midwait_level", int'(db_level), 0);
        check("midwait_tick", int'(db_tick), 0);
        steps(2);
        tick_cnt = 0;
        rst = 1'b0;
        steps(45);
        check("midwait_requal_ticks", tick_cnt, 1);
        check("midwait_requal_level", int'(db_level), 1);
        $display("reset mid-wait: requalified ticks %0d", tick_cnt);

        // Random hold lengths against the model.
        for (int t = 0; t < 80; t++) begin
            int hold;
            hold = $urandom_range(1, 45);
            sw = 1'($urandom_range(0, 1));
            steps(hold);
        end
        $display("random: 80 segments compared against model");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
